// File: rtl/gated_event_counter.sv
// Multi-channel gated event counter: synchronise, debounce and edge-detect each input,
// then count matching edges inside a programmable window and snapshot at window close.
module gated_event_counter #(
   parameter int CHANNELS     = 4,
   parameter int COUNT_W      = 8,
   parameter int WINDOW_W     = 12,
   parameter int SYNC_STAGES  = 3,
   parameter int DEBOUNCE_LEN = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [CHANNELS-1:0]          data_in,
   input  logic [1:0]                   edge_mode,
   input  logic [WINDOW_W-1:0]          window_len,
   output logic                         running,
   output logic                         ready,
   output logic [CHANNELS-1:0]          overflow,
   output logic [CHANNELS*COUNT_W-1:0]  count_out,
   output logic [1:0]                   dbg_state
);

   localparam int DB_W = (DEBOUNCE_LEN < 2) ? 1 : $clog2(DEBOUNCE_LEN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                                 r_state;
   state_t                                 w_state_next;
   logic [WINDOW_W-1:0]                    r_timer;
   logic [1:0]                             r_mode;

   logic [CHANNELS-1:0][SYNC_STAGES-1:0]   r_sync;
   logic [CHANNELS-1:0]                    w_sync;
   logic [CHANNELS-1:0]                    r_db;
   logic [CHANNELS-1:0]                    r_db_prev;
   logic [CHANNELS-1:0][DB_W-1:0]          r_db_cnt;
   logic [CHANNELS-1:0]                    r_pulse;

   logic [CHANNELS-1:0][COUNT_W-1:0]       r_cnt;
   logic [CHANNELS-1:0][COUNT_W-1:0]       w_cnt_next;
   logic [CHANNELS-1:0]                    r_ovf;
   logic [CHANNELS-1:0]                    w_ovf_next;
   logic [CHANNELS-1:0][COUNT_W-1:0]       r_count_out;
   logic [CHANNELS-1:0]                    r_overflow;
   logic                                   w_done_entry;

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         w_sync[c] = r_sync[c][SYNC_STAGES-1];
      end
   end

   // Front end runs in every state; only the latched edge mode gates the pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync    <= '0;
         r_db      <= '0;
         r_db_prev <= '0;
         r_db_cnt  <= '0;
         r_pulse   <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], data_in[c]};
            if (w_sync[c] == r_db[c]) begin
               r_db_cnt[c] <= '0;
            end else if (r_db_cnt[c] == DB_W'(DEBOUNCE_LEN - 1)) begin
               r_db[c]     <= w_sync[c];
               r_db_cnt[c] <= '0;
            end else begin
               r_db_cnt[c] <= r_db_cnt[c] + 1'b1;
            end
            r_pulse[c] <= (r_db[c] & ~r_db_prev[c] & r_mode[0]) |
                          (~r_db[c] & r_db_prev[c] & r_mode[1]);
         end
         r_db_prev <= r_db;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_CLEAR;
         S_CLEAR: w_state_next = (window_len != '0) ? S_RUN : S_DONE;
         S_RUN:   if (r_timer == WINDOW_W'(1)) w_state_next = S_DONE;
         S_DONE:  if (start) w_state_next = S_CLEAR;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_next = r_cnt;
      w_ovf_next = r_ovf;
      if (r_state == S_CLEAR) begin
         w_cnt_next = '0;
         w_ovf_next = '0;
      end else if (r_state == S_RUN) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (r_pulse[c]) begin
               if (r_cnt[c] == '1) w_ovf_next[c] = 1'b1;
               else                w_cnt_next[c] = r_cnt[c] + 1'b1;
            end
         end
      end
   end

   // Snapshot uses next-state counts so an increment in the last RUN cycle is kept.
   assign w_done_entry = (w_state_next == S_DONE) && (r_state != S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_mode      <= '0;
         r_cnt       <= '0;
         r_ovf       <= '0;
         r_count_out <= '0;
         r_overflow  <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_ovf   <= w_ovf_next;
         if (r_state == S_CLEAR) begin
            r_mode  <= edge_mode;
            r_timer <= window_len;
         end else if (r_state == S_RUN) begin
            r_timer <= r_timer - 1'b1;
         end
         if (w_done_entry) begin
            r_count_out <= w_cnt_next;
            r_overflow  <= w_ovf_next;
         end
      end
   end

   assign running   = (r_state == S_RUN);
   assign ready     = (r_state == S_DONE);
   assign overflow  = r_overflow;
   assign count_out = r_count_out;
   assign dbg_state = r_state;

endmodule
